codebook_b10_f_dec: RTL and testbench

Bit-serial decoder for the codebook-10 terminal (flush) codewords of the hybrid low-entropy coder. It accepts the compressed bitstream one bit per handshake, MSB-first, and accumulates bits until it sees a complete 12/13/17/18-bit flush codeword. It then emits the active-prefix length and the hex-digit active-prefix word that the encoder-side table consumed. It sits in the decompression path, after the bitstream unpacker, and feeds the low-entropy symbol reconstruction stage.

---
 rtl/codebook_b10_f_dec.sv | 150 +++++++++++++++
 tb/tb_codebook_b10_f_dec.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/codebook_b10_f_dec.sv
// Bit-serial decoder for the codebook-10 flush codewords: collects MSB-first bits
// until a 12/13/17/18-bit codeword matches, then presents its active-prefix length and word.
module codebook_b10_f_dec #(
  parameter int CODEBOOK_LENGTH_MAX = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           bit_valid_i,
  input  logic                           bit_i,
  output logic                           bit_ready_o,
  output logic                           ap_valid_o,
  input  logic                           ap_ready_i,
  output logic [5:0]                     ap_cnt_o,
  output logic [CODEBOOK_LENGTH_MAX-1:0] ap_data_o,
  output logic                           ap_err_o
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t      state, state_next;
  // The 18th bit never lands in sr: every 18-bit candidate either matches or errors and clears.
  logic [16:0] sr;
  logic [4:0]  len;
  logic [4:0]  len_next;
  logic [17:0] cand;
  logic        accept;
  logic        hit;
  logic        load;
  logic        load_err;
  logic [53:0] entry;
  logic [5:0]  cnt13;

  assign bit_ready_o = (state == ACCUM) || ap_ready_i;
  assign ap_valid_o  = (state == HOLD);
  assign accept      = bit_valid_i && bit_ready_o;
  assign cand        = {sr, bit_i};
  assign len_next    = len + 5'd1;
  assign cnt13       = {3'b000, cand[2:0]} + 6'd3;

  // Table lookup: entry packs {cnt, data}; a non-zero cnt marks a hit.
  always_comb begin
    entry = '0;
    case (len_next)
      5'd12: begin
        case (cand[11:0])
          12'hFFA: entry = {6'd1, 48'hF};
          12'hFFB: entry = {6'd2, 48'h0F};
          default: entry = '0;
        endcase
      end
      5'd13: begin
        if (cand[12:3] == 10'h3FF && cand[2:0] != 3'h7)
          entry = {cnt13, 48'hF};
      end
      5'd17: begin
        case (cand[16:0])
          17'h1FFF0: entry = {6'd2, 48'h1F};
          17'h1FFF1: entry = {6'd3, 48'h01F};
          17'h1FFF2: entry = {6'd3, 48'h10F};
          17'h1FFF3: entry = {6'd4, 48'h001F};
          17'h1FFF4: entry = {6'd4, 48'h010F};
          17'h1FFF5: entry = {6'd4, 48'h100F};
          17'h1FFF6: entry = {6'd6, 48'h00002F};
          default:   entry = '0;
        endcase
      end
      5'd18: begin
        case (cand)
          18'h3FFEE: entry = {6'd7,  48'h000002F};
          18'h3FFEF: entry = {6'd7,  48'h000020F};
          18'h3FFF0: entry = {6'd8,  48'h0000002F};
          18'h3FFF1: entry = {6'd8,  48'h0000020F};
          18'h3FFF2: entry = {6'd8,  48'h0000200F};
          18'h3FFF3: entry = {6'd9,  48'h00000001F};
          18'h3FFF4: entry = {6'd9,  48'h00000002F};
          18'h3FFF5: entry = {6'd9,  48'h00000020F};
          18'h3FFF6: entry = {6'd9,  48'h00000200F};
          18'h3FFF7: entry = {6'd9,  48'h00002000F};
          18'h3FFF8: entry = {6'd10, 48'h000000001F};
          18'h3FFF9: entry = {6'd10, 48'h000000002F};
          18'h3FFFA: entry = {6'd10, 48'h000000010F};
          18'h3FFFB: entry = {6'd10, 48'h000000020F};
          18'h3FFFC: entry = {6'd11, 48'h0000000010F};
          18'h3FFFD: entry = {6'd11, 48'h0000000100F};
          18'h3FFFE: entry = {6'd12, 48'h00000000100F};
          18'h3FFFF: entry = {6'd12, 48'h00000001000F};
          default:   entry = '0;
        endcase
      end
      default: entry = '0;
    endcase
  end

  assign hit = (entry[53:48] != 6'd0);

  // A pending result is released by ap_ready_i; a completing codeword reloads in the same cycle.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_err   = 1'b0;
    if (state == HOLD && ap_ready_i)
      state_next = ACCUM;
    if (accept) begin
      if (hit) begin
        load       = 1'b1;
        state_next = HOLD;
      end else if (len_next == 5'd18) begin
        load_err   = 1'b1;
        state_next = HOLD;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      state <= ACCUM;
    else
      state <= state_next;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sr  <= '0;
      len <= '0;
    end else if (load || load_err) begin
      sr  <= '0;
      len <= '0;
    end else if (accept) begin
      sr  <= cand[16:0];
      len <= len_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ap_cnt_o  <= '0;
      ap_data_o <= '0;
      ap_err_o  <= 1'b0;
    end else if (load) begin
      ap_cnt_o  <= entry[53:48];
      ap_data_o <= CODEBOOK_LENGTH_MAX'(entry[47:0]);
      ap_err_o  <= 1'b0;
    end else if (load_err) begin
      ap_cnt_o  <= '0;
      ap_data_o <= '0;
      ap_err_o  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_codebook_b10_f_dec.sv
// Self-checking bench for codebook_b10_f_dec: directed steps plus a randomized sweep,
// checked against a table rebuilt from the textual codebook listing.
module tb_codebook_b10_f_dec;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         bit_valid = 1'b0;
  logic         bit_in = 1'b0;
  logic         ap_ready = 1'b0;
  logic         bit_ready;
  logic         ap_valid;
  logic [5:0]   ap_cnt;
  logic [W-1:0] ap_data;
  logic         ap_err;

  codebook_b10_f_dec #(.CODEBOOK_LENGTH_MAX(W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .bit_valid_i(bit_valid), .bit_i(bit_in),
    .bit_ready_o(bit_ready), .ap_valid_o(ap_valid), .ap_ready_i(ap_ready),
    .ap_cnt_o(ap_cnt), .ap_data_o(ap_data), .ap_err_o(ap_err)
  );

  always #5 clk = ~clk;

  string tbl17 [7] = '{"2:1F", "3:01F", "3:10F", "4:001F", "4:010F", "4:100F", "6:00002F"};
  string tbl18 [18] = '{"7:000002F", "7:000020F", "8:0000002F", "8:0000020F", "8:0000200F",
                        "9:00000001F", "9:00000002F", "9:00000020F", "9:00000200F", "9:00002000F",
                        "10:000000001F", "10:000000002F", "10:000000010F", "10:000000020F",
                        "11:0000000010F", "11:0000000100F", "12:00000000100F", "12:00000001000F"};

  int          cw_val [34];
  int          cw_len [34];
  int          ex_cnt [34];
  logic [63:0] ex_data [34];
  int          exp_q [$];
  int          vectors = 0;
  int          miscompares = 0;
  int          stalls = 0;

  // "cnt:HEX" -> numeric cnt and zero-extended hex word
  function automatic void parse_entry(input string s, output int cnt, output logic [63:0] data);
    bit in_data = 0;
    byte ch;
    cnt = 0;
    data = '0;
    for (int i = 0; i < s.len(); i++) begin
      ch = s[i];
      if (ch == 8'd58) in_data = 1;
      else if (!in_data) cnt = cnt * 10 + int'(ch - 8'd48);
      else if (ch <= 8'd57) data = (data << 4) | 64'(ch - 8'd48);
      else data = (data << 4) | 64'(ch - 8'd55);
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, sample outputs 1ns later, score any handshake.
  task automatic cycle(input logic v, input logic b, input logic r, output logic acc);
    int idx;
    @(negedge clk);
    bit_valid = v;
    bit_in = b;
    ap_ready = r;
    #1;
    acc = v && bit_ready;
    if (v && !acc) stalls++;
    if (ap_valid && r) begin
      if (exp_q.size() == 0) begin
        check("spurious_result", 64'(exp_q.size()), 64'd1);
      end else begin
        idx = exp_q.pop_front();
        if (idx < 0) begin
          check("err_cnt", 64'(ap_cnt), 64'd0);
          check("err_data", ap_data, 64'd0);
          check("err_flag", 64'(ap_err), 64'd1);
        end else begin
          check($sformatf("cnt[%0h]", cw_val[idx]), 64'(ap_cnt), 64'(ex_cnt[idx]));
          check($sformatf("data[%0h]", cw_val[idx]), ap_data, ex_data[idx]);
          check($sformatf("err[%0h]", cw_val[idx]), 64'(ap_err), 64'd0);
        end
      end
    end
  endtask

  task automatic send_bit(input logic b, input bit gaps, input bit bp);
    logic acc = 1'b0;
    logic v, r;
    int tries = 0;
    while (!acc) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      r = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      cycle(v, b, r, acc);
      tries++;
      if (!acc && tries > 200) begin
        check("bit_accept_timeout", 64'(acc), 64'd1);
        break;
      end
    end
  endtask

  task automatic send_raw(input int val, input int len, input bit gaps, input bit bp);
    for (int i = len - 1; i >= 0; i--) send_bit(val[i], gaps, bp);
  endtask

  // idx < 0 sends eighteen zeros, which is no codeword at all
  task automatic send_cw(input int idx, input bit gaps, input bit bp);
    exp_q.push_back(idx);
    if (idx < 0) send_raw(0, 18, gaps, bp);
    else send_raw(cw_val[idx], cw_len[idx], gaps, bp);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) cycle(1'b0, 1'b0, 1'b1, acc);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bit_ready"}, 64'(bit_ready), 64'd1);
    check({tag, "_ap_valid"}, 64'(ap_valid), 64'd0);
    check({tag, "_ap_cnt"}, 64'(ap_cnt), 64'd0);
    check({tag, "_ap_data"}, ap_data, 64'd0);
    check({tag, "_ap_err"}, 64'(ap_err), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [34];
    int k, j, t;
    logic acc;
    string s;

    // Build the reference table from the codebook listing
    parse_entry("1:F", ex_cnt[0], ex_data[0]);  cw_val[0] = 'hFFA; cw_len[0] = 12;
    parse_entry("2:0F", ex_cnt[1], ex_data[1]); cw_val[1] = 'hFFB; cw_len[1] = 12;
    for (int c = 3; c <= 9; c++) begin
      s = $sformatf("%0d:", c);
      for (int z = 0; z < c - 1; z++) s = {s, "0"};
      s = {s, "F"};
      k = c - 1;
      parse_entry(s, ex_cnt[k], ex_data[k]);
      cw_val[k] = 'h1FF8 + (c - 3); cw_len[k] = 13;
    end
    for (int i = 0; i < 7; i++) begin
      parse_entry(tbl17[i], ex_cnt[9 + i], ex_data[9 + i]);
      cw_val[9 + i] = 'h1FFF0 + i; cw_len[9 + i] = 17;
    end
    for (int i = 0; i < 18; i++) begin
      parse_entry(tbl18[i], ex_cnt[16 + i], ex_data[16 + i]);
      cw_val[16 + i] = 'h3FFEE + i; cw_len[16 + i] = 18;
    end

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 0xFFA back-to-back: one valid pulse right after the 12th bit
    send_cw(0, 0, 0);
    cycle(1'b0, 1'b0, 1'b1, acc);
    check("ffa_latency", 64'(exp_q.size()), 64'd0);
    cycle(1'b0, 1'b0, 1'b1, acc);
    check("ffa_single_pulse", 64'(ap_valid), 64'd0);

    // 0x1FFE then 0x3FFFF with no bubble between them
    stalls = 0;
    send_cw(8, 0, 0);
    send_cw(33, 0, 0);
    drain();
    check("back_to_back_stalls", 64'(stalls), 64'd0);

    // All 34 codewords, random order, random gaps and backpressure
    for (int i = 0; i < 34; i++) order[i] = i;
    for (int i = 33; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 34; i++) send_cw(order[i], 1, 1);
    drain();

    // Invalid 18-bit word, then 0xFFB decodes normally
    send_cw(-1, 0, 0);
    send_cw(1, 0, 0);
    drain();

    // Backpressure holds the 0x1FFF6 result and blocks further bits
    send_cw(15, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 1'b0, acc);
      check("hold_valid", 64'(ap_valid), 64'd1);
      check("hold_cnt", 64'(ap_cnt), 64'd6);
      check("hold_data", ap_data, 64'h2F);
      check("hold_bit_ready", 64'(bit_ready), 64'd0);
    end
    drain();
    send_cw(0, 0, 0);
    drain();

    // Reset after 9 bits of 0x3FFEE discards the partial word
    send_raw('h3FFEE >> 9, 9, 0, 0);
    @(negedge clk);
    bit_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    send_cw(16, 0, 0);
    drain();

    // Reset while a result is pending discards it
    send_cw(0, 0, 0);
    @(negedge clk);
    bit_valid = 1'b0;
    ap_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("pending_reset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send_cw(1, 0, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
